// File: rtl/axil_reg_bank.sv
// AXI4-Lite slave register bank: ID, CTRL, STATUS (sticky W1C), SCRATCH and a
// saturating event counter. Independent write and read paths, one outstanding
// transaction each. Every output is driven from a flop or from flop-only logic.
module axil_reg_bank #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] ID_VALUE = 32'h5052_0001,
  parameter logic [31:0] CTRL_RST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] s_awaddr,
  input  logic              s_awvalid,
  output logic              s_awready,
  input  logic [31:0]       s_wdata,
  input  logic [3:0]        s_wstrb,
  input  logic              s_wvalid,
  output logic              s_wready,
  output logic [1:0]        s_bresp,
  output logic              s_bvalid,
  input  logic              s_bready,
  input  logic [ADDR_W-1:0] s_araddr,
  input  logic              s_arvalid,
  output logic              s_arready,
  output logic [31:0]       s_rdata,
  output logic [1:0]        s_rresp,
  output logic              s_rvalid,
  input  logic              s_rready,
  output logic [31:0]       ctrl_o,
  input  logic [31:0]       status_set_i,
  input  logic              evt_i
);

  localparam logic [31:0] BAD_DATA    = 32'hDEAD_BEEF;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;
  localparam logic [2:0]  SEL_ID      = 3'd0;
  localparam logic [2:0]  SEL_CTRL    = 3'd1;
  localparam logic [2:0]  SEL_STATUS  = 3'd2;
  localparam logic [2:0]  SEL_SCRATCH = 3'd3;
  localparam logic [2:0]  SEL_EVCNT   = 3'd4;

  // The commit step happens on the edge that leaves W_IDLE, so the register
  // update and bvalid both become visible the cycle after the later handshake.
  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

  // Word-aligned and within the five implemented registers.
  function automatic logic addr_ok(input logic [4:0] a);
    return (a[1:0] == 2'b00) && (a[4:2] <= SEL_EVCNT);
  endfunction

  // Address bits above [4] alias the map and are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{s_awaddr[ADDR_W-1:5], s_araddr[ADDR_W-1:5]};

  w_state_t    w_state_q, w_state_d;
  r_state_t    r_state_q, r_state_d;
  logic        aw_held_q, aw_held_d;
  logic        w_held_q, w_held_d;
  logic [4:0]  awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] status_q, status_d;
  logic [31:0] scratch_q, scratch_d;
  logic [31:0] evcnt_q, evcnt_d;

  logic        aw_hs, w_hs, commit, wr_ok;
  logic [4:0]  eff_addr;
  logic [31:0] eff_wdata, wmask, rd_word;
  logic [3:0]  eff_wstrb;

  assign s_awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign s_wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign s_bvalid  = (w_state_q == W_RESP);
  assign s_bresp   = bresp_q;
  assign s_arready = (r_state_q == R_IDLE);
  assign s_rvalid  = (r_state_q == R_DATA);
  assign s_rdata   = rdata_q;
  assign s_rresp   = rresp_q;
  assign ctrl_o    = ctrl_q;

  assign aw_hs     = s_awvalid && s_awready;
  assign w_hs      = s_wvalid && s_wready;
  // Use the held beat if one is waiting, otherwise the beat arriving now.
  assign eff_addr  = aw_held_q ? awaddr_q : s_awaddr[4:0];
  assign eff_wdata = w_held_q ? wdata_q : s_wdata;
  assign eff_wstrb = w_held_q ? wstrb_q : s_wstrb;
  assign commit    = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_ok     = commit && addr_ok(eff_addr);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wmask
      assign wmask[gi*8 +: 8] = {8{eff_wstrb[gi]}};
    end
  endgenerate

  // Write path: capture AW and W independently, commit once both are present.
  always_comb begin
    w_state_d = w_state_q;
    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr[4:0];
        end
        if (w_hs) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (commit) begin
          aw_held_d = 1'b0;
          w_held_d  = 1'b0;
          bresp_d   = addr_ok(eff_addr) ? RESP_OKAY : RESP_SLVERR;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Register file next state: writes under byte strobes, sticky status, counter.
  always_comb begin
    // CTRL bit 0 is a one-cycle clear strobe, so it always falls back to 0.
    ctrl_d    = {ctrl_q[31:1], 1'b0};
    scratch_d = scratch_q;
    status_d  = status_q;
    if (wr_ok && eff_addr[4:2] == SEL_CTRL)
      ctrl_d = (ctrl_d & ~wmask) | (eff_wdata & wmask);
    if (wr_ok && eff_addr[4:2] == SEL_SCRATCH)
      scratch_d = (scratch_q & ~wmask) | (eff_wdata & wmask);
    if (wr_ok && eff_addr[4:2] == SEL_STATUS)
      status_d = status_q & ~(eff_wdata & wmask);
    // A set pulse overrides a simultaneous clear of the same bit.
    status_d = status_d | status_set_i;
    if (ctrl_q[0])
      evcnt_d = '0;
    else if (evt_i && (evcnt_q != 32'hFFFF_FFFF))
      evcnt_d = evcnt_q + 32'd1;
    else
      evcnt_d = evcnt_q;
  end

  // Read decode from the pre-write register values.
  always_comb begin
    case (s_araddr[4:2])
      SEL_ID:      rd_word = ID_VALUE;
      SEL_CTRL:    rd_word = ctrl_q;
      SEL_STATUS:  rd_word = status_q;
      SEL_SCRATCH: rd_word = scratch_q;
      SEL_EVCNT:   rd_word = evcnt_q;
      default:     rd_word = BAD_DATA;
    endcase
  end

  // Read path: accept AR in R_IDLE, hold the response until rready.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_arvalid) begin
          rdata_d   = addr_ok(s_araddr[4:0]) ? rd_word : BAD_DATA;
          rresp_d   = addr_ok(s_araddr[4:0]) ? RESP_OKAY : RESP_SLVERR;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_rready) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // Write path state; reset drops any partially captured transaction.
  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read path state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Register file.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl_q    <= CTRL_RST;
      status_q  <= '0;
      scratch_q <= '0;
      evcnt_q   <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      status_q  <= status_d;
      scratch_q <= scratch_d;
      evcnt_q   <= evcnt_d;
    end
  end

endmodule

// File: tb/tb_axil_reg_bank.sv
// Directed bench for axil_reg_bank: a register-level model tracks the bus
// handshakes and checks every output each cycle; directed reads add literal
// expectations.
module tb_axil_reg_bank;
  localparam int          ADDR_W = 8;
  localparam logic [31:0] ID     = 32'h5052_0001;
  localparam logic [31:0] CRST   = 32'h0000_0000;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] s_awaddr, s_araddr;
  logic              s_awvalid, s_awready, s_wvalid, s_wready;
  logic [31:0]       s_wdata, s_rdata, ctrl_o, status_set_i;
  logic [3:0]        s_wstrb;
  logic [1:0]        s_bresp, s_rresp;
  logic              s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
  logic              evt_i;

  always #5 clk = ~clk;

  axil_reg_bank #(.ADDR_W(ADDR_W), .ID_VALUE(ID), .CTRL_RST(CRST)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .ctrl_o(ctrl_o), .status_set_i(status_set_i), .evt_i(evt_i)
  );

  int n_vec = 0;
  int n_err = 0;
  bit armed = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: register contents and outstanding responses ----
  logic [31:0] m_ctrl, m_status, m_scratch, m_evcnt;
  bit          m_aw_held, m_w_held;
  logic [7:0]  m_awaddr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wstrb;
  logic [33:0] rq[$];   // {rresp, rdata} expected per accepted read
  logic [1:0]  bq[$];   // bresp expected per committed write
  bit          preload_now = 1'b0;
  logic [31:0] preload_val = '0;

  function automatic logic [33:0] model_read(input logic [7:0] a);
    if (a[1:0] != 2'b00) return {2'b10, 32'hDEAD_BEEF};
    case (a[4:2])
      3'd0:    return {2'b00, ID};
      3'd1:    return {2'b00, m_ctrl};
      3'd2:    return {2'b00, m_status};
      3'd3:    return {2'b00, m_scratch};
      3'd4:    return {2'b00, m_evcnt};
      default: return {2'b10, 32'hDEAD_BEEF};
    endcase
  endfunction

  task automatic model_step();
    logic [7:0]  a;
    logic [31:0] d, bm, clr, nctrl, nscr, nevc;
    logic [3:0]  s;
    bit          ha, hw;
    if (!rst) begin
      m_ctrl = CRST; m_status = '0; m_scratch = '0; m_evcnt = '0;
      m_aw_held = 1'b0; m_w_held = 1'b0;
      rq.delete(); bq.delete();
      return;
    end
    if (s_rvalid && s_rready && rq.size() > 0) void'(rq.pop_front());
    if (s_bvalid && s_bready && bq.size() > 0) void'(bq.pop_front());
    if (s_arvalid && s_arready) rq.push_back(model_read(s_araddr));
    ha = m_aw_held; a = m_awaddr; hw = m_w_held; d = m_wdata; s = m_wstrb;
    if (s_awvalid && s_awready) begin ha = 1'b1; a = s_awaddr; end
    if (s_wvalid && s_wready) begin hw = 1'b1; d = s_wdata; s = s_wstrb; end
    nctrl = m_ctrl & ~32'h1;
    nscr  = m_scratch;
    clr   = '0;
    if (ha && hw) begin
      bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      if (a[1:0] == 2'b00 && a[4:2] <= 3'd4) begin
        bq.push_back(2'b00);
        case (a[4:2])
          3'd1:    nctrl = (nctrl & ~bm) | (d & bm);
          3'd2:    clr   = d & bm;
          3'd3:    nscr  = (nscr & ~bm) | (d & bm);
          default: ;
        endcase
      end else begin
        bq.push_back(2'b10);
      end
      ha = 1'b0; hw = 1'b0;
    end
    if (m_ctrl[0]) nevc = '0;
    else if (evt_i && m_evcnt != 32'hFFFF_FFFF) nevc = m_evcnt + 1;
    else nevc = m_evcnt;
    if (preload_now) nevc = preload_val;
    m_aw_held = ha; m_awaddr = a; m_w_held = hw; m_wdata = d; m_wstrb = s;
    m_status  = (m_status & ~clr) | status_set_i;
    m_ctrl    = nctrl;
    m_scratch = nscr;
    m_evcnt   = nevc;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (armed) begin
      check("cmp_ctrl_o", ctrl_o, m_ctrl);
      check("cmp_awready", s_awready, (bq.size() == 0 && !m_aw_held));
      check("cmp_wready", s_wready, (bq.size() == 0 && !m_w_held));
      check("cmp_bvalid", s_bvalid, (bq.size() != 0));
      if (s_bvalid && bq.size() != 0) check("cmp_bresp", s_bresp, bq[0]);
      check("cmp_arready", s_arready, (rq.size() == 0));
      check("cmp_rvalid", s_rvalid, (rq.size() != 0));
      if (s_rvalid && rq.size() != 0) begin
        check("cmp_rdata", s_rdata, rq[0][31:0]);
        check("cmp_rresp", s_rresp, rq[0][33:32]);
      end
    end
  end

  // ---------------- bus tasks ---------------------------------------------
  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int bstall, input logic [31:0] set_pulse,
                           output logic [1:0] resp);
    bit aw_done = 1'b0, w_done = 1'b0, ah, wh;
    int cyc = 0;
    @(posedge clk); #1;
    s_awaddr = a; s_wdata = d; s_wstrb = s; s_wvalid = 1'b1;
    s_awvalid = (w_lead == 0); status_set_i = set_pulse;
    if (bstall > 0) s_bready = 1'b0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge clk);
      ah = s_awvalid && s_awready;
      wh = s_wvalid && s_wready;
      @(posedge clk); #1;
      status_set_i = '0;
      cyc++;
      if (ah) begin s_awvalid = 1'b0; aw_done = 1'b1; end
      if (wh) begin s_wvalid = 1'b0; w_done = 1'b1; end
      if (!aw_done && !s_awvalid && cyc >= w_lead) s_awvalid = 1'b1;
    end
    if (!(aw_done && w_done)) begin
      check("aw_w_handshake_timeout", 0, 1);
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_bready = 1'b1; resp = 2'bxx;
      return;
    end
    @(negedge clk);
    check("b_latency", s_bvalid, 1);
    resp = s_bresp;
    for (int i = 0; i < bstall; i++) begin
      @(posedge clk); @(negedge clk);
      check("b_hold", s_bvalid, 1);
    end
    s_bready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    bit hs = 1'b0;
    int cyc = 0;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1'b1;
    while (!hs && cyc < 40) begin
      @(negedge clk);
      hs = s_arready;
      @(posedge clk); #1;
      cyc++;
    end
    s_arvalid = 1'b0;
    if (!hs) begin
      check("ar_handshake_timeout", 0, 1);
      d = 'x; r = 'x;
      return;
    end
    @(negedge clk);
    check("r_latency", s_rvalid, 1);
    d = s_rdata; r = s_rresp;
    @(posedge clk); #1;
  endtask

  // ---------------- directed sequence -------------------------------------
  logic [31:0] rd;
  logic [1:0]  rr, br;

  initial begin
    rst = 1'b0; s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
    status_set_i = '0; evt_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; armed = 1'b1;

    @(negedge clk);
    check("rst_awready", s_awready, 1);
    check("rst_wready", s_wready, 1);
    check("rst_arready", s_arready, 1);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    check("rst_rdata", s_rdata, 0);
    check("rst_bresp", s_bresp, 0);
    check("rst_ctrl_o", ctrl_o, CRST);

    axi_read(8'h00, rd, rr);
    check("id_data", rd, 32'h5052_0001);
    check("id_resp", rr, 2'b00);
    axi_read(8'h04, rd, rr);
    check("ctrl_rst_read", rd, CRST);

    // Byte-strobed scratch writes, AW and W together.
    axi_write(8'h0C, 32'hA5A5_5A5A, 4'hF, 0, 0, '0, br);
    check("scr_bresp", br, 2'b00);
    axi_write(8'h0C, 32'h1111_2222, 4'h3, 0, 0, '0, br);
    axi_read(8'h0C, rd, rr);
    check("scr_strobe", rd, 32'hA5A5_2222);

    // Same again with W leading AW by 3 cycles and a 5-cycle B stall.
    axi_write(8'h0C, 32'h0000_0000, 4'hF, 0, 0, '0, br);
    axi_write(8'h0C, 32'hA5A5_5A5A, 4'hF, 3, 0, '0, br);
    axi_write(8'h0C, 32'h1111_2222, 4'h3, 3, 5, '0, br);
    check("scr_wlead_bresp", br, 2'b00);
    axi_read(8'h0C, rd, rr);
    check("scr_wlead", rd, 32'hA5A5_2222);

    // Sticky status and W1C.
    @(posedge clk); #1 status_set_i = 32'h0000_0081;
    @(posedge clk); #1 status_set_i = '0;
    axi_write(8'h08, 32'h0000_0001, 4'hF, 0, 0, '0, br);
    axi_read(8'h08, rd, rr);
    check("status_w1c", rd, 32'h0000_0080);
    axi_write(8'h08, 32'h0000_0080, 4'hF, 0, 0, 32'h0000_0080, br);
    axi_read(8'h08, rd, rr);
    check("status_set_wins", rd, 32'h0000_0080);
    axi_write(8'h08, 32'h0000_0080, 4'hE, 0, 0, '0, br);
    axi_read(8'h08, rd, rr);
    check("status_strb_off", rd, 32'h0000_0080);
    axi_write(8'h08, 32'h0000_0080, 4'h1, 0, 0, '0, br);
    axi_read(8'h08, rd, rr);
    check("status_cleared", rd, 32'h0000_0000);

    // Event counter, then clear via CTRL[0] while events keep arriving.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1 evt_i = 1'b1;
      @(posedge clk); #1 evt_i = 1'b0;
    end
    axi_read(8'h10, rd, rr);
    check("evcnt_10", rd, 32'd10);
    @(posedge clk); #1 evt_i = 1'b1;
    axi_write(8'h04, 32'h0000_0001, 4'hF, 0, 0, '0, br);
    evt_i = 1'b0;
    axi_read(8'h10, rd, rr);
    check("evcnt_clear_wins", rd, 32'd0);
    axi_read(8'h04, rd, rr);
    check("ctrl_selfclear", rd, 32'd0);

    // Saturation from a forced preload.
    @(negedge clk);
    preload_val = 32'hFFFF_FFFD; preload_now = 1'b1;
    force dut.evcnt_q = 32'hFFFF_FFFD;
    @(posedge clk); #1;
    release dut.evcnt_q;
    preload_now = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1 evt_i = 1'b1;
      @(posedge clk); #1 evt_i = 1'b0;
    end
    axi_read(8'h10, rd, rr);
    check("evcnt_saturate", rd, 32'hFFFF_FFFF);

    // CTRL under strobes; ctrl_o valid right after the response.
    axi_write(8'h04, 32'h1234_56FF, 4'hE, 0, 0, '0, br);
    check("ctrl_o_strobe", ctrl_o, 32'h1234_5600);

    // Invalid accesses and aliasing.
    axi_read(8'h18, rd, rr);
    check("bad_read_data", rd, 32'hDEAD_BEEF);
    check("bad_read_resp", rr, 2'b10);
    axi_write(8'h06, 32'hFFFF_FFFF, 4'hF, 0, 0, '0, br);
    check("bad_write_unaligned", br, 2'b10);
    axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, 0, 0, '0, br);
    check("bad_write_hole", br, 2'b10);
    axi_read(8'h0C, rd, rr);
    check("scr_unchanged", rd, 32'hA5A5_2222);
    axi_read(8'h20, rd, rr);
    check("alias_id", rd, ID);

    // Reset with a write response pending.
    s_bready = 1'b0;
    @(posedge clk); #1;
    s_awaddr = 8'h0C; s_wdata = 32'h0BAD_0BAD; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(posedge clk); #1 s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    check("rst1_b_pending", s_bvalid, 1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; s_bready = 1'b1;
    @(negedge clk);
    check("rst1_bvalid", s_bvalid, 0);
    check("rst1_awready", s_awready, 1);
    check("rst1_ctrl_o", ctrl_o, CRST);
    check("rst1_rdata", s_rdata, 0);
    axi_read(8'h0C, rd, rr);
    check("rst1_scratch", rd, 32'h0);

    // Reset with AW captured but no W yet.
    @(posedge clk); #1 s_awaddr = 8'h04; s_awvalid = 1'b1;
    @(posedge clk); #1 s_awvalid = 1'b0;
    @(negedge clk);
    check("rst2_aw_held", s_awready, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("rst2_awready", s_awready, 1);
    check("rst2_wready", s_wready, 1);
    axi_write(8'h0C, 32'h600D_F00D, 4'hF, 0, 0, '0, br);
    check("rst2_bresp", br, 2'b00);
    axi_read(8'h0C, rd, rr);
    check("rst2_scratch", rd, 32'h600D_F00D);
    axi_read(8'h04, rd, rr);
    check("rst2_ctrl", rd, CRST);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
